trace_monitor_core: RTL and testbench

TRACE_MONITOR_CORE -- requirements
Module: trace_monitor

---
 rtl/trace_monitor_core.sv | 83 ++++++++
 tb/tb_trace_monitor_core.sv | 127 ++++++++++++
 2 files changed

// File: rtl/trace_monitor_core.sv
// trace_monitor_core: decodes l.nop simulation hooks (exit/report/putc) at writeback into registered pulses and sticky state.
module trace_monitor_core #(
    parameter int ID = 0,
    parameter int ENABLE_TRACE = 0,
    parameter STDOUT_FILENAME = "stdout",
    parameter TRACEFILE_FILENAME = "trace",
    parameter int TERM_CROSS_NUM = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [31:0]               wb_pc,
    input  logic [31:0]               wb_insn,
    input  logic [31:0]               r3,
    input  logic [TERM_CROSS_NUM-1:0] termination_all,
    output logic                      termination,
    output logic                      all_done,
    output logic [31:0]               exit_code,
    output logic                      putc_valid,
    output logic [7:0]                putc_char,
    output logic                      report_valid,
    output logic [31:0]               report_value
);
    logic        is_nop;
    logic [15:0] k;
    logic        ev_exit, ev_report, ev_putc;

    assign is_nop    = enable && (wb_insn[31:16] == 16'h1500) && !termination;
    assign k         = wb_insn[15:0];
    assign ev_exit   = is_nop && (k == 16'h0001);
    assign ev_report = is_nop && (k == 16'h0002);
    assign ev_putc   = is_nop && (k == 16'h0004);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            termination  <= 1'b0;
            all_done     <= 1'b0;
            exit_code    <= '0;
            putc_valid   <= 1'b0;
            putc_char    <= '0;
            report_valid <= 1'b0;
            report_value <= '0;
        end else begin
            putc_valid   <= ev_putc;
            report_valid <= ev_report;
            if (ev_putc)
                putc_char <= r3[7:0];
            if (ev_report)
                report_value <= r3;
            if (ev_exit) begin
                termination <= 1'b1;
                exit_code   <= r3;
            end
            if (&termination_all)
                all_done <= 1'b1;
        end
    end

    logic unused_cfg;
    assign unused_cfg = ^{wb_pc, ID[0], ENABLE_TRACE[0], STDOUT_FILENAME[0], TRACEFILE_FILENAME[0]};

`ifdef TRACE_MONITOR_FILE_IO_EN
    logic done_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= all_done;
            if (ev_putc)
                $write("%c", r3[7:0]);
            if (ev_report)
                $write("[%0t, %0d] report: 0x%h\n", $time, ID, r3);
            if (ev_exit)
                $write("[%0t, %0d] exit(%0d)\n", $time, ID, r3);
            if ((ENABLE_TRACE != 0) && enable)
                $write("%0t %h %h\n", $time, wb_pc, wb_insn);
            if (done_q)
                $finish;
        end
    end
`endif
endmodule

// File: tb/tb_trace_monitor_core.sv
// tb_trace_monitor_core: directed vectors feed a scoreboard queue; a monitor pops and compares registered outputs each cycle.
module tb_trace_monitor_core;
    typedef struct packed {
        logic        term;
        logic        done;
        logic [31:0] ec;
        logic        pv;
        logic [7:0]  pc;
        logic        rv;
        logic [31:0] rval;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_insn = '0;
    logic [31:0] r3 = '0;
    logic [3:0]  termination_all = '0;
    logic        termination, all_done, putc_valid, report_valid;
    logic [31:0] exit_code, report_value;
    logic [7:0]  putc_char;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    trace_monitor_core #(.ID(3), .TERM_CROSS_NUM(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wb_pc(wb_pc), .wb_insn(wb_insn), .r3(r3),
        .termination_all(termination_all), .termination(termination), .all_done(all_done),
        .exit_code(exit_code), .putc_valid(putc_valid), .putc_char(putc_char),
        .report_valid(report_valid), .report_value(report_value)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic t, input logic d, input logic [31:0] ec, input logic pv,
                                input logic [7:0] pc, input logic rv, input logic [31:0] rval);
        mk = '{term: t, done: d, ec: ec, pv: pv, pc: pc, rv: rv, rval: rval};
    endfunction

    function automatic obs_t cur();
        cur = '{term: termination, done: all_done, ec: exit_code, pv: putc_valid, pc: putc_char,
                rv: report_valid, rval: report_value};
    endfunction

    task automatic step(input string nm, input logic en, input logic [31:0] insn, input logic [31:0] v,
                        input logic [3:0] tall, input obs_t e);
        enable = en;
        wb_insn = insn;
        wb_pc = wb_pc + 32'd4;
        r3 = v;
        termination_all = tall;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input obs_t e);
        obs_t a;
        a = cur();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got term=%b done=%b ec=%h pv=%b pc=%h rv=%b rval=%h want term=%b done=%b ec=%h pv=%b pc=%h rv=%b rval=%h",
                     nm, a.term, a.done, a.ec, a.pv, a.pc, a.rv, a.rval, e.term, e.done, e.ec, e.pv, e.pc, e.rv, e.rval);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check(name_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step("idle",         0, 32'h0000_0000, 32'h0,         4'b0000, mk(0, 0, 0, 0, 8'h00, 0, 32'h0));
        step("putc_a",       1, 32'h1500_0004, 32'h41,        4'b0000, mk(0, 0, 0, 1, 8'h41, 0, 32'h0));
        step("putc_drop",    0, 32'h0000_0000, 32'h0,         4'b0000, mk(0, 0, 0, 0, 8'h41, 0, 32'h0));
        step("putc_b2b_1",   1, 32'h1500_0004, 32'h142,       4'b0000, mk(0, 0, 0, 1, 8'h42, 0, 32'h0));
        step("putc_b2b_2",   1, 32'h1500_0004, 32'h43,        4'b0000, mk(0, 0, 0, 1, 8'h43, 0, 32'h0));
        step("report",       1, 32'h1500_0002, 32'hDEADBEEF,  4'b0000, mk(0, 0, 0, 0, 8'h43, 1, 32'hDEADBEEF));
        step("report_drop",  0, 32'h1500_0004, 32'h55,        4'b0000, mk(0, 0, 0, 0, 8'h43, 0, 32'hDEADBEEF));
        step("nop_k3",       1, 32'h1500_0003, 32'h66,        4'b0000, mk(0, 0, 0, 0, 8'h43, 0, 32'hDEADBEEF));
        step("non_nop",      1, 32'h1501_0004, 32'h67,        4'b0000, mk(0, 0, 0, 0, 8'h43, 0, 32'hDEADBEEF));
        step("partial_done", 0, 32'h0000_0000, 32'h0,         4'b0111, mk(0, 0, 0, 0, 8'h43, 0, 32'hDEADBEEF));
        step("exit",         1, 32'h1500_0001, 32'h7,         4'b0111, mk(1, 0, 7, 0, 8'h43, 0, 32'hDEADBEEF));
        step("putc_post",    1, 32'h1500_0004, 32'h41,        4'b0111, mk(1, 0, 7, 0, 8'h43, 0, 32'hDEADBEEF));
        step("report_post",  1, 32'h1500_0002, 32'h1234,      4'b0111, mk(1, 0, 7, 0, 8'h43, 0, 32'hDEADBEEF));
        step("exit_post",    1, 32'h1500_0001, 32'h9,         4'b0111, mk(1, 0, 7, 0, 8'h43, 0, 32'hDEADBEEF));
        step("all_done",     0, 32'h0000_0000, 32'h0,         4'b1111, mk(1, 1, 7, 0, 8'h43, 0, 32'hDEADBEEF));
        step("done_sticky",  0, 32'h0000_0000, 32'h0,         4'b0000, mk(1, 1, 7, 0, 8'h43, 0, 32'hDEADBEEF));
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 8'h00, 0, 32'h0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step("resume_putc",  1, 32'h1500_0004, 32'h5A,        4'b0000, mk(0, 0, 0, 1, 8'h5A, 0, 32'h0));
        step("resume_exit",  1, 32'h1500_0001, 32'hFFFF_FFFE, 4'b0000, mk(1, 0, 32'hFFFF_FFFE, 0, 8'h5A, 0, 32'h0));
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
